// File: rtl/rgb_tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// rgb_link_pkg
// Shared constants and types for the receive side of the 4:1 time-division
// RGB link.
//   SLOTS  : beats per frame (slots per colour channel), power of two >= 2
//   SEL_W  : width of the remote mux select / slot counter, log2(SLOTS)
//   CH     : number of colour channels (R, G, B)
//   FCNT_W : width of the completed-frame counter
// -----------------------------------------------------------------------------
package rgb_link_pkg;

    localparam int SLOTS  = 4;
    localparam int SEL_W  = 2;
    localparam int CH     = 3;
    localparam int FCNT_W = 8;

    // Channel positions inside in_bit and out_word
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // HUNT: waiting for a sync beat; COLLECT: mid-frame
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage : rgb_link_pkg

// File: rtl/rgb_tdm_demux_if.sv
// -----------------------------------------------------------------------------
// rgb_tdm_demux_if
// Bundles the serial beat inputs and the reassembled-frame outputs of the
// RGB TDM receiver.
//   in_valid  : beat qualifier
//   in_sync   : beat is slot 0 of a frame
//   in_bit    : one serial bit per colour channel
//   sel_out   : slot expected on the next accepted beat (remote mux select)
//   out_word  : last complete frame, bit [c*SLOTS+s] = channel c, slot s
//   out_valid : one-cycle pulse when out_word updates
//   sync_err  : one-cycle pulse on an early sync
//   frame_cnt : completed-frame counter, wraps
// Modports: master = beat source / frame consumer, slave = the receiver.
// -----------------------------------------------------------------------------
interface rgb_tdm_demux_if
    import rgb_link_pkg::*;
#(
    parameter int P_SLOTS  = SLOTS,
    parameter int P_SEL_W  = SEL_W,
    parameter int P_CH     = CH,
    parameter int P_FCNT_W = FCNT_W
) ();

    logic                      in_valid;
    logic                      in_sync;
    logic [P_CH-1:0]           in_bit;
    logic [P_SEL_W-1:0]        sel_out;
    logic [P_CH*P_SLOTS-1:0]   out_word;
    logic                      out_valid;
    logic                      sync_err;
    logic [P_FCNT_W-1:0]       frame_cnt;

    modport master (
        output in_valid, in_sync, in_bit,
        input  sel_out, out_word, out_valid, sync_err, frame_cnt
    );

    modport slave (
        input  in_valid, in_sync, in_bit,
        output sel_out, out_word, out_valid, sync_err, frame_cnt
    );

endinterface : rgb_tdm_demux_if

// File: rtl/rgb_tdm_demux_slot_capture.sv
// -----------------------------------------------------------------------------
// tdm_slot_capture
// One colour channel's partial-frame register: SLOTS bits, one per slot,
// written one bit at a time at the slot index supplied by the frame FSM.
//   clk, rst_n : clock, asynchronous active-low reset (clears the partial frame)
//   wr_en      : write the incoming bit this cycle
//   wr_slot    : slot position to write
//   bit_in     : serial bit for this channel
//   bits_next  : register contents including this cycle's write, so the top
//                can latch a complete frame on the same edge as its last beat
// -----------------------------------------------------------------------------
module tdm_slot_capture #(
    parameter int SLOTS = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_slot,
    input  logic             bit_in,
    output logic [SLOTS-1:0] bits_next
);

    logic [SLOTS-1:0] bits_r;

    // Next partial-frame value: merge the incoming bit at its slot
    always_comb begin
        bits_next = bits_r;
        if (wr_en) begin
            bits_next[wr_slot] = bit_in;
        end else begin
            bits_next = bits_r;
        end
    end

    // Partial-frame storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_r <= {SLOTS{1'b0}};
        end else begin
            bits_r <= bits_next;
        end
    end

endmodule : tdm_slot_capture

// File: rtl/rgb_tdm_demux.sv
// -----------------------------------------------------------------------------
// rgb_tdm_demux
// Receive side of the 4:1 time-division RGB link. Drives the remote select
// as a slot counter, samples one bit per colour channel on each accepted
// beat, and publishes each completed 12-bit frame with a valid strobe,
// an early-sync error strobe and a wrapping frame counter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rgb_tdm_demux_if.slave (beat inputs, frame outputs)
// -----------------------------------------------------------------------------
module rgb_tdm_demux
    import rgb_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    rgb_tdm_demux_if.slave    bus
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);
    localparam logic [SEL_W-1:0] SLOT_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t                        state_r;
    logic [SEL_W-1:0]              slot_r;
    logic                          wr_en_s;
    logic [SEL_W-1:0]              wr_slot_s;
    logic [CH-1:0][SLOTS-1:0]      frame_next_s;
    logic [CH*SLOTS-1:0]           out_word_r;
    logic                          out_valid_r;
    logic                          sync_err_r;
    logic [FCNT_W-1:0]             frame_cnt_r;

    // Capture enable: any sync beat restarts at slot 0; plain beats are kept
    // only mid-frame (a plain beat while hunting is discarded)
    always_comb begin
        wr_en_s   = 1'b0;
        wr_slot_s = slot_r;
        if (bus.in_valid) begin
            if (bus.in_sync) begin
                wr_en_s   = 1'b1;
                wr_slot_s = SLOT_ZERO;
            end else if (state_r == COLLECT) begin
                wr_en_s   = 1'b1;
                wr_slot_s = slot_r;
            end else begin
                wr_en_s   = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        tdm_slot_capture #(
            .SLOTS (SLOTS),
            .SEL_W (SEL_W)
        ) u_capture (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en_s),
            .wr_slot   (wr_slot_s),
            .bit_in    (bus.in_bit[c]),
            .bits_next (frame_next_s[c])
        );
    end

    // Frame FSM with slot counter and registered frame/strobe outputs.
    // Completing a frame returns to HUNT on the same edge, so a sync on the
    // very next beat starts the next frame with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            slot_r      <= SLOT_ZERO;
            out_word_r  <= {(CH*SLOTS){1'b0}};
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            frame_cnt_r <= {FCNT_W{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            if (bus.in_valid) begin
                case (state_r)
                    HUNT: begin
                        if (bus.in_sync) begin
                            slot_r  <= SLOT_ONE;
                            state_r <= COLLECT;
                        end else begin
                            slot_r  <= SLOT_ZERO;
                            state_r <= HUNT;
                        end
                    end
                    COLLECT: begin
                        if (bus.in_sync) begin
                            // Early sync: drop the partial frame, restart at slot 1
                            sync_err_r <= 1'b1;
                            slot_r     <= SLOT_ONE;
                            state_r    <= COLLECT;
                        end else if (slot_r == LAST_SLOT) begin
                            out_word_r  <= frame_next_s;
                            out_valid_r <= 1'b1;
                            frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
                            slot_r      <= SLOT_ZERO;
                            state_r     <= HUNT;
                        end else begin
                            slot_r <= slot_r + SLOT_ONE;
                        end
                    end
                    default: begin
                        slot_r  <= SLOT_ZERO;
                        state_r <= HUNT;
                    end
                endcase
            end else begin
                slot_r  <= slot_r;
                state_r <= state_r;
            end
        end
    end

    assign bus.sel_out   = slot_r;
    assign bus.out_word  = out_word_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sync_err  = sync_err_r;
    assign bus.frame_cnt = frame_cnt_r;

endmodule : rgb_tdm_demux

// File: tb/tb_rgb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_rgb_tdm_demux
// Self-checking bench for rgb_tdm_demux: a directed vector table, hand-written
// corner sequences and random beats, all compared against a queue-based
// reference model of the framing rules.
// -----------------------------------------------------------------------------
module tb_rgb_tdm_demux;

    logic clk;
    logic rst_n;

    rgb_tdm_demux_if bus ();

    rgb_tdm_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    bit         m_collecting;
    logic [2:0] m_beats[$];
    logic [11:0] m_word;
    logic       m_valid;
    logic       m_err;
    int         m_fcnt;

    function automatic void model_reset();
        m_collecting = 1'b0;
        m_beats.delete();
        m_word  = 12'h000;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fcnt  = 0;
    endfunction

    function automatic void model_beat(input logic v, input logic s, input logic [2:0] b);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (s) begin
                if (m_collecting) m_err = 1'b1;
                m_beats.delete();
                m_beats.push_back(b);
                m_collecting = 1'b1;
            end else if (m_collecting) begin
                m_beats.push_back(b);
                if (m_beats.size() == 4) begin
                    for (int sl = 0; sl < 4; sl++)
                        for (int ch = 0; ch < 3; ch++)
                            m_word[ch*4 + sl] = m_beats[sl][ch];
                    m_valid = 1'b1;
                    m_fcnt  = (m_fcnt + 1) % 256;
                    m_collecting = 1'b0;
                    m_beats.delete();
                end
            end
        end
    endfunction

    function automatic int model_sel();
        return m_collecting ? m_beats.size() : 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sel_out"},   32'(bus.sel_out),   model_sel());
        chk({tag, ".out_word"},  32'(bus.out_word),  32'(m_word));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".sync_err"},  32'(bus.sync_err),  32'(m_err));
        chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), m_fcnt);
    endtask

    // Drive one cycle from the falling edge, update the model on the rising
    // edge, and leave the caller at the next falling edge for sampling.
    task automatic step(input logic v, input logic s, input logic [2:0] b);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_bit   = b;
        @(posedge clk);
        model_beat(v, s, b);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic        s;
        logic [2:0]  b;
        logic [1:0]  sel;
        logic [11:0] word;
        logic        val;
        logic        err;
        logic [7:0]  fcnt;
    } vec_t;

    vec_t tbl[14];

    int valid_pulses;
    int last_valid;
    int cyc;

    initial begin
        // Frame R/G/B per slot: s0 {1,0,1}, s1 {0,1,1}, s2 {1,1,0}, s3 {0,0,1}
        // -> R=0101, G=0110, B=1011 -> 12'hB65
        tbl[0]  = '{1'b1, 1'b1, 3'b101, 2'd1, 12'h000, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 3'b110, 2'd2, 12'h000, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 3'b011, 2'd3, 12'h000, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 3'b100, 2'd0, 12'hB65, 1'b1, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 1'b0, 3'b000, 2'd0, 12'hB65, 1'b0, 1'b0, 8'd1};
        // Same frame with three idle cycles (garbage on the bus) after slot 1
        tbl[5]  = '{1'b1, 1'b1, 3'b101, 2'd1, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 3'b110, 2'd2, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 3'b111, 2'd2, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 3'b010, 2'd2, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 1'b1, 3'b000, 2'd2, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 2'd3, 12'hB65, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 3'b100, 2'd0, 12'hB65, 1'b1, 1'b0, 8'd2};
        // Plain beat while hunting is discarded silently
        tbl[12] = '{1'b1, 1'b0, 3'b111, 2'd0, 12'hB65, 1'b0, 1'b0, 8'd2};
        tbl[13] = '{1'b0, 1'b0, 3'b000, 2'd0, 12'hB65, 1'b0, 1'b0, 8'd2};

        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_bit   = 3'b000;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].b);
            chk($sformatf("tbl%0d.sel_out", i),   32'(bus.sel_out),   32'(tbl[i].sel));
            chk($sformatf("tbl%0d.out_word", i),  32'(bus.out_word),  32'(tbl[i].word));
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].val));
            chk($sformatf("tbl%0d.sync_err", i),  32'(bus.sync_err),  32'(tbl[i].err));
            chk($sformatf("tbl%0d.frame_cnt", i), 32'(bus.frame_cnt), 32'(tbl[i].fcnt));
        end

        // Early sync at slot 2: error pulse, frame dropped, sync beat is new slot 0
        step(1'b1, 1'b1, 3'b001); check_model("early0");
        step(1'b1, 1'b0, 3'b010); check_model("early1");
        step(1'b1, 1'b1, 3'b111);
        check_model("early_sync");
        chk("early_err_pulse", 32'(bus.sync_err), 1);
        chk("early_word_held", 32'(bus.out_word), 32'h00000B65);
        step(1'b1, 1'b0, 3'b000); check_model("early3");
        chk("early_err_cleared", 32'(bus.sync_err), 0);
        step(1'b1, 1'b0, 3'b111); check_model("early4");
        step(1'b1, 1'b0, 3'b000); check_model("early5");
        // Slots 0 and 2 all ones -> each nibble 0101
        chk("early_frame_word", 32'(bus.out_word), 32'h00000555);
        chk("early_frame_valid", 32'(bus.out_valid), 1);

        // Eight plain beats while hunting: nothing happens
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'($urandom_range(0, 7)));
            check_model($sformatf("nosync%0d", i));
            chk($sformatf("nosync%0d.sel_zero", i), 32'(bus.sel_out), 0);
        end

        // Asynchronous reset in the middle of a frame
        step(1'b1, 1'b1, 3'b111);
        step(1'b1, 1'b0, 3'b101);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        @(negedge clk);
        check_model("async_reset_held");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'b000);
        check_model("after_reset");

        // 256 back-to-back random frames, no idle cycles
        valid_pulses = 0;
        last_valid   = -1;
        cyc          = 0;
        for (int f = 0; f < 256; f++) begin
            for (int sl = 0; sl < 4; sl++) begin
                step(1'b1, (sl == 0), 3'($urandom_range(0, 7)));
                check_model("b2b");
                if (bus.out_valid) begin
                    valid_pulses++;
                    if (last_valid >= 0) chk("b2b_spacing", cyc - last_valid, 4);
                    last_valid = cyc;
                end
                cyc++;
            end
        end
        chk("b2b_pulse_count", valid_pulses, 256);
        chk("b2b_fcnt_wrap", 32'(bus.frame_cnt), 0);

        // Random beats with random gaps, syncs and bits
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)));
            check_model("rand");
            if (bus.out_valid && bus.sync_err) chk("rand_exclusive", 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rgb_tdm_demux
